// File: rtl/dbg_uart_pkg.sv
// Shared types and constants for the debug UART scheduler: FSM states,
// header tag and source-id width.
package dbg_uart_pkg;

  localparam int ID_W = 2;
  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    H_ACK,
    H_DONE,
    PAY,
    P_ACK,
    P_DONE
  } state_t;

  // Header byte: tag in the high nibble, source id in the low bits.
  function automatic logic [7:0] hdr_byte(input logic [ID_W-1:0] id);
    return {HDR_TAG, {(4 - ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/dbg_fifo.sv
// Per-source byte FIFO. A push into a full FIFO is accepted when a pop
// frees a slot in the same cycle.
module dbg_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define emptiness, so stale data is never read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dbg_uart_sched.sv
// Round-robin scheduler sharing one debug UART between NSRC byte sources;
// each grant sends a header byte (tag | id) followed by the payload byte.
module dbg_uart_sched
  import dbg_uart_pkg::*;
#(
  parameter int NSRC   = 3,
  parameter int DEPTH  = 4,
  parameter int ACK_TO = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NSRC-1:0]   src_valid,
  input  logic [8*NSRC-1:0] src_data,
  output logic [NSRC-1:0]   src_drop,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              tx_err,
  output logic [7:0]        drop_cnt
);

  localparam int CNT_W = $clog2(ACK_TO + 1);

  state_t            state, state_next;
  logic [NSRC-1:0]   full, empty, push, pop, drop;
  logic [7:0]        fifo_rdata [NSRC];
  logic [ID_W-1:0]   last_grant, grant_id, cand;
  logic              grant_valid, grant, timeout;
  logic [7:0]        payload;
  logic [CNT_W-1:0]  ack_cnt;
  logic [8:0]        drop_sum;
  logic [7:0]        drop_cnt_next;

  for (genvar i = 0; i < NSRC; i++) begin : g_fifo
    dbg_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (src_data[8*i +: 8]),
      .rdata (fifo_rdata[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // Writes: a full FIFO still accepts the byte when it is popped this cycle.
  always_comb begin
    push     = src_valid & {NSRC{en}};
    drop     = push & full & ~pop;
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < NSRC; i++) drop_sum = drop_sum + 9'(drop[i]);
    drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Round-robin search starting just after the last granted source.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= NSRC; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NSRC);
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = '0;
    grant      = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && grant_valid) begin
          grant          = 1'b1;
          pop[grant_id]  = 1'b1;
          state_next     = HDR;
        end
      end
      HDR:  state_next = H_ACK;
      H_ACK: begin
        if (tx_busy) begin
          state_next = H_DONE;
        end else if (ack_cnt == CNT_W'(ACK_TO - 1)) begin
          timeout    = 1'b1;
          state_next = PAY;
        end
      end
      H_DONE: if (!tx_busy) state_next = PAY;
      PAY:  state_next = P_ACK;
      P_ACK: begin
        if (tx_busy) begin
          state_next = P_DONE;
        end else if (ack_cnt == CNT_W'(ACK_TO - 1)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      P_DONE: if (!tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ack_cnt counts cycles since tx_start; tx_err is registered, so it lands
  // exactly ACK_TO cycles after the start pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= ID_W'(NSRC - 1);
      payload    <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      tx_err     <= 1'b0;
      src_drop   <= '0;
      drop_cnt   <= '0;
      ack_cnt    <= '0;
    end else begin
      tx_start <= (state_next == HDR) || (state_next == PAY);
      tx_err   <= timeout;
      src_drop <= drop;
      drop_cnt <= drop_cnt_next;
      if (grant) begin
        last_grant <= grant_id;
        payload    <= fifo_rdata[grant_id];
        tx_data    <= hdr_byte(grant_id);
      end
      if (state_next == PAY) tx_data <= payload;
      if (state == HDR || state == PAY)          ack_cnt <= CNT_W'(1);
      else if (state == H_ACK || state == P_ACK) ack_cnt <= ack_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dbg_uart_sched.sv
// Scenario bench for dbg_uart_sched: expected UART bytes are queued when
// stimulus is driven and compared in order as each tx_start appears.
module tb_dbg_uart_sched;

  localparam int NSRC   = 3;
  localparam int ACK_TO = 16;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              en        = 1'b1;
  logic [NSRC-1:0]   src_valid = '0;
  logic [8*NSRC-1:0] src_data  = '0;
  logic [NSRC-1:0]   src_drop;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              tx_err;
  logic [7:0]        drop_cnt;

  logic hold_busy = 1'b0;
  logic uart_busy = 1'b0;
  logic uart_on   = 1'b1;

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  int         start_cyc[$];
  int         err_cyc[$];
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int         drop_pulses[NSRC] = '{default: 0};

  assign tx_busy = hold_busy | uart_busy;

  dbg_uart_sched #(.NSRC(NSRC), .DEPTH(4), .ACK_TO(ACK_TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_drop  (src_drop),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_err    (tx_err),
    .drop_cnt  (drop_cnt)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy rises one cycle after a start and stays high 10 cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (uart_on && tx_start === 1'b1 && !reset) begin
        @(posedge clk);
        #1 uart_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 uart_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every start pops one expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
      end else begin
        if (tx_start === 1'b1) begin
          start_cyc.push_back(cyc);
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_start: cycle %0d tx_data=%h, nothing expected", cyc, tx_data);
          end else begin
            exp_b = sb.pop_front();
            if (tx_data !== exp_b) begin
              fails++;
              $display("FAIL tx_byte: cycle %0d tx_data=%h, expected %h", cyc, tx_data, exp_b);
            end
          end
        end
        if (tx_err === 1'b1) err_cyc.push_back(cyc);
        for (int i = 0; i < NSRC; i++) if (src_drop[i] === 1'b1) drop_pulses[i]++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input logic [NSRC-1:0] v, input logic [8*NSRC-1:0] d);
    @(negedge clk);
    src_valid = v;
    src_data  = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    src_valid = '0;
    hold_busy = 1'b0;
    en        = 1'b1;
    uart_on   = 1'b1;
    repeat (12) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int k = 0; k < budget && start_cyc.size() < n; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    int base;
    repeat (3) @(negedge clk);
    tests += 5;
    if (tx_start !== 1'b0) begin fails++; $display("FAIL rst_tx_start: got %b, expected 0", tx_start); end
    if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data: got %h, expected 00", tx_data); end
    if (src_drop !== '0)   begin fails++; $display("FAIL rst_src_drop: got %b, expected 000", src_drop); end
    if (tx_err !== 1'b0)   begin fails++; $display("FAIL rst_tx_err: got %b, expected 0", tx_err); end
    if (drop_cnt !== 8'h00) begin fails++; $display("FAIL rst_drop_cnt: got %0d, expected 0", drop_cnt); end
    base  = start_cyc.size();
    reset = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (start_cyc.size() != base) begin
      fails++;
      $display("FAIL rst_idle: %0d starts after reset, expected 0", start_cyc.size() - base);
    end
  endtask

  task automatic test_single_byte();
    int base, v;
    apply_reset();
    base = start_cyc.size();
    sb.push_back(8'hA1);
    sb.push_back(8'h5C);
    @(negedge clk);
    v         = cyc;
    src_valid = 3'b010;
    src_data  = {8'h00, 8'h5C, 8'h00};
    drive('0, '0);
    wait_starts(base + 2, 80);
    tests++;
    if (start_cyc.size() < base + 2) begin
      fails++;
      $display("FAIL single_timeout: %0d starts, expected 2", start_cyc.size() - base);
    end else begin
      tests += 2;
      if (start_cyc[base] != v + 2) begin
        fails++;
        $display("FAIL single_latency: header start at cycle %0d, expected %0d", start_cyc[base], v + 2);
      end
      if (start_cyc[base+1] != start_cyc[base] + 12) begin
        fails++;
        $display("FAIL single_hdr_gap: payload start at cycle %0d, expected %0d",
                 start_cyc[base+1], start_cyc[base] + 12);
      end
    end
    repeat (30) @(negedge clk);
    tests++;
    if (start_cyc.size() != base + 2 || sb.size() != 0) begin
      fails++;
      $display("FAIL single_idle: %0d starts with %0d bytes pending, expected 2 and 0",
               start_cyc.size() - base, sb.size());
    end
  endtask

  task automatic test_enable();
    int base;
    base = start_cyc.size();
    @(negedge clk);
    en = 1'b0;
    drive(3'b001, {8'h00, 8'h00, 8'hEE});
    drive('0, '0);
    repeat (20) @(negedge clk);
    en = 1'b1;
    tests++;
    if (start_cyc.size() != base) begin
      fails++;
      $display("FAIL enable_gate: %0d starts with en low, expected 0", start_cyc.size() - base);
    end
  endtask

  task automatic test_fairness();
    int base, rel;
    apply_reset();
    hold_busy = 1'b1;
    drive(3'b111, {8'h30, 8'h20, 8'h10});
    drive(3'b111, {8'h31, 8'h21, 8'h11});
    drive('0, '0);
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NSRC; s++) begin
        sb.push_back(8'hA0 | 8'(s));
        sb.push_back(8'(16 * (s + 1) + r));
      end
    end
    base = start_cyc.size();
    @(negedge clk);
    rel       = cyc;
    hold_busy = 1'b0;
    wait_starts(base + 12, 400);
    tests++;
    if (start_cyc.size() < base + 12) begin
      fails++;
      $display("FAIL fair_timeout: %0d starts, expected 12", start_cyc.size() - base);
    end else begin
      tests += 3;
      if (start_cyc[base] != rel + 1) begin
        fails++;
        $display("FAIL fair_first: first start at cycle %0d, expected %0d", start_cyc[base], rel + 1);
      end
      if (start_cyc[base+2] != start_cyc[base+1] + 13) begin
        fails++;
        $display("FAIL fair_b2b: next header at cycle %0d, expected %0d",
                 start_cyc[base+2], start_cyc[base+1] + 13);
      end
      if (sb.size() != 0) begin
        fails++;
        $display("FAIL fair_pending: %0d bytes unsent, expected 0", sb.size());
      end
    end
  endtask

  task automatic test_overflow();
    int d0, d1, d2, base;
    apply_reset();
    d0 = drop_pulses[0];
    d1 = drop_pulses[1];
    d2 = drop_pulses[2];
    hold_busy = 1'b1;
    for (int k = 0; k < 6; k++) drive(3'b100, {8'(8'h40 + k), 16'h0000});
    drive('0, '0);
    repeat (2) @(negedge clk);
    tests += 3;
    if (drop_pulses[2] - d2 != 2) begin
      fails++;
      $display("FAIL ovf_pulses: %0d src_drop[2] pulses, expected 2", drop_pulses[2] - d2);
    end
    if (drop_pulses[0] != d0 || drop_pulses[1] != d1) begin
      fails++;
      $display("FAIL ovf_other: pulses on sources 0/1 = %0d/%0d, expected 0/0",
               drop_pulses[0] - d0, drop_pulses[1] - d1);
    end
    if (drop_cnt !== 8'd2) begin fails++; $display("FAIL ovf_cnt: drop_cnt=%0d, expected 2", drop_cnt); end
    for (int k = 0; k < 252; k++) drive(3'b100, {8'hF0, 16'h0000});
    drive('0, '0);
    repeat (2) @(negedge clk);
    tests++;
    if (drop_cnt !== 8'd254) begin fails++; $display("FAIL ovf_cnt254: drop_cnt=%0d, expected 254", drop_cnt); end
    for (int k = 0; k < 48; k++) drive(3'b100, {8'hF1, 16'h0000});
    drive('0, '0);
    repeat (2) @(negedge clk);
    tests++;
    if (drop_cnt !== 8'd255) begin fails++; $display("FAIL ovf_sat: drop_cnt=%0d, expected 255", drop_cnt); end
    for (int k = 0; k < 4; k++) begin
      sb.push_back(8'hA2);
      sb.push_back(8'(8'h40 + k));
    end
    base = start_cyc.size();
    hold_busy = 1'b0;
    wait_starts(base + 8, 300);
    repeat (20) @(negedge clk);
    tests++;
    if (start_cyc.size() != base + 8 || sb.size() != 0) begin
      fails++;
      $display("FAIL ovf_drain: %0d starts with %0d bytes pending, expected 8 and 0",
               start_cyc.size() - base, sb.size());
    end
  endtask

  task automatic test_push_pop_full();
    int d0, base;
    apply_reset();
    d0 = drop_pulses[0];
    hold_busy = 1'b1;
    for (int k = 0; k < 4; k++) drive(3'b001, {16'h0000, 8'(8'h50 + k)});
    drive('0, '0);
    for (int k = 0; k < 5; k++) begin
      sb.push_back(8'hA0);
      sb.push_back(8'(8'h50 + k));
    end
    base = start_cyc.size();
    @(negedge clk);
    hold_busy = 1'b0;
    src_valid = 3'b001;
    src_data  = {16'h0000, 8'h54};
    drive('0, '0);
    wait_starts(base + 10, 400);
    repeat (5) @(negedge clk);
    tests += 3;
    if (drop_pulses[0] != d0) begin
      fails++;
      $display("FAIL pp_drop: %0d drop pulses, expected 0", drop_pulses[0] - d0);
    end
    if (drop_cnt !== 8'd0) begin fails++; $display("FAIL pp_cnt: drop_cnt=%0d, expected 0", drop_cnt); end
    if (start_cyc.size() != base + 10 || sb.size() != 0) begin
      fails++;
      $display("FAIL pp_drain: %0d starts with %0d bytes pending, expected 10 and 0",
               start_cyc.size() - base, sb.size());
    end
  endtask

  task automatic test_no_busy();
    int base, ebase, v;
    apply_reset();
    uart_on = 1'b0;
    base  = start_cyc.size();
    ebase = err_cyc.size();
    sb.push_back(8'hA1);
    sb.push_back(8'h77);
    drive(3'b010, {8'h00, 8'h77, 8'h00});
    drive('0, '0);
    for (int k = 0; k < 120 && err_cyc.size() < ebase + 2; k++) @(negedge clk);
    tests++;
    if (err_cyc.size() < ebase + 2 || start_cyc.size() < base + 2) begin
      fails++;
      $display("FAIL nobusy_timeout: %0d errors and %0d starts, expected 2 and 2",
               err_cyc.size() - ebase, start_cyc.size() - base);
    end else begin
      tests += 3;
      if (err_cyc[ebase] != start_cyc[base] + ACK_TO) begin
        fails++;
        $display("FAIL nobusy_err1: tx_err at cycle %0d, expected %0d", err_cyc[ebase], start_cyc[base] + ACK_TO);
      end
      if (start_cyc[base+1] != start_cyc[base] + ACK_TO) begin
        fails++;
        $display("FAIL nobusy_pay: payload start at cycle %0d, expected %0d",
                 start_cyc[base+1], start_cyc[base] + ACK_TO);
      end
      if (err_cyc[ebase+1] != start_cyc[base+1] + ACK_TO) begin
        fails++;
        $display("FAIL nobusy_err2: tx_err at cycle %0d, expected %0d",
                 err_cyc[ebase+1], start_cyc[base+1] + ACK_TO);
      end
    end
    tests++;
    if (err_cyc.size() != ebase + 2) begin
      fails++;
      $display("FAIL nobusy_errcount: %0d error pulses, expected 2", err_cyc.size() - ebase);
    end
    sb.push_back(8'hA0);
    sb.push_back(8'h78);
    @(negedge clk);
    v         = cyc;
    src_valid = 3'b001;
    src_data  = {16'h0000, 8'h78};
    drive('0, '0);
    wait_starts(base + 3, 20);
    tests++;
    if (start_cyc.size() < base + 3 || start_cyc[base+2] != v + 2) begin
      fails++;
      $display("FAIL nobusy_idle: %0d starts, next header not at cycle %0d", start_cyc.size() - base, v + 2);
    end
    for (int k = 0; k < 120 && err_cyc.size() < ebase + 4; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    tests++;
    if (err_cyc.size() != ebase + 4 || sb.size() != 0) begin
      fails++;
      $display("FAIL nobusy_second: %0d errors with %0d bytes pending, expected 4 and 0",
               err_cyc.size() - ebase, sb.size());
    end
    uart_on = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int base, p, v;
    apply_reset();
    base = start_cyc.size();
    sb.push_back(8'hA1);
    sb.push_back(8'h66);
    drive(3'b010, {8'h00, 8'h66, 8'h00});
    drive('0, '0);
    wait_starts(base + 2, 80);
    tests++;
    if (start_cyc.size() < base + 2) begin
      fails++;
      $display("FAIL midrst_timeout: %0d starts, expected 2", start_cyc.size() - base);
      p = cyc;
    end else begin
      p = start_cyc[base+1];
    end
    drive(3'b101, {8'h88, 8'h00, 8'h99});
    drive('0, '0);
    for (int k = 0; k < 20 && cyc < p + 5; k++) @(negedge clk);
    reset = 1'b1;
    #1;
    tests += 5;
    if (tx_start !== 1'b0) begin fails++; $display("FAIL midrst_start: got %b, expected 0", tx_start); end
    if (tx_data !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h, expected 00", tx_data); end
    if (src_drop !== '0)   begin fails++; $display("FAIL midrst_drop: got %b, expected 000", src_drop); end
    if (tx_err !== 1'b0)   begin fails++; $display("FAIL midrst_err: got %b, expected 0", tx_err); end
    if (drop_cnt !== 8'h00) begin fails++; $display("FAIL midrst_cnt: got %0d, expected 0", drop_cnt); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base  = start_cyc.size();
    repeat (20) @(negedge clk);
    tests++;
    if (start_cyc.size() != base) begin
      fails++;
      $display("FAIL midrst_empty: %0d starts after reset, expected 0", start_cyc.size() - base);
    end
    sb.push_back(8'hA0);
    sb.push_back(8'hC0);
    sb.push_back(8'hA2);
    sb.push_back(8'hC2);
    @(negedge clk);
    v         = cyc;
    src_valid = 3'b101;
    src_data  = {8'hC2, 8'h00, 8'hC0};
    drive('0, '0);
    wait_starts(base + 4, 120);
    tests++;
    if (start_cyc.size() < base + 4 || start_cyc[base] != v + 2 || sb.size() != 0) begin
      fails++;
      $display("FAIL midrst_regrant: %0d starts, %0d bytes pending, first header expected at cycle %0d",
               start_cyc.size() - base, sb.size(), v + 2);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_enable();
    test_fairness();
    test_overflow();
    test_push_pop_full();
    test_no_busy();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dbg_uart_sched.md
# dbg_uart_sched

Round-robin scheduler that shares the single debug UART transmitter between three byte sources in the FSK demodulator (recovered symbol bytes, bit-decision byte, status byte). Each source has a small private FIFO. The scheduler picks the next non-empty FIFO and sends a two-byte frame, header then payload, through the transmitter's start/busy handshake. It sits between the demodulator outputs and the UART transmitter, all in the 200 MHz system clock domain.

## Interface
- NSRC, 3, number of sources (2..4); the source id is 2 bits
- DEPTH, 4, per-source FIFO depth (power of 2)
- ACK_TO, 16, cycles to wait for tx_busy to rise after tx_start

Ports:
- clk  in  1  system clock, 200 MHz; the only clock
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  level; when low, src_valid is ignored (queued bytes still drain)
- src_valid  in  NSRC  one-cycle write strobe per source, already in the clk domain
- src_data  in  8*NSRC  source i byte at bits [8i+7:8i]
- src_drop  out  NSRC  one-cycle pulse: write lost because the FIFO was full
- tx_data  out  8  byte to the UART; held stable from tx_start until tx_busy falls
- tx_start  out  1  one-cycle start pulse
- tx_busy  in  1  UART busy flag
- tx_err  out  1  one-cycle pulse on ACK timeout
- drop_cnt  out  8  total dropped writes, saturates at 255

## Operation
- Write: src_valid[i] && en && FIFO i not full pushes src_data[i]. If FIFO i is full, the byte is discarded, src_drop[i] pulses and drop_cnt increments (saturating).
- Full FIFO with a push and a pop in the same cycle: the pop frees a slot, the write is accepted and there is no drop.
- Arbitration, in IDLE with tx_busy low: search sources starting at last_grant+1, wrapping modulo NSRC; the first non-empty source wins. In the same cycle: pop its head into the payload register, record the id in last_grant, go to HDR. last_grant resets to NSRC-1, so source 0 has priority first.
- FSM states: IDLE, HDR, H_ACK, H_DONE, PAY, P_ACK, P_DONE.
  - IDLE -> HDR on a grant.
  - HDR: tx_start=1, tx_data = 8'hA0 | id. Next state H_ACK.
  - H_ACK -> H_DONE when tx_busy=1. After ACK_TO cycles without busy, pulse tx_err and go to PAY (the header is treated as sent).
  - H_DONE -> PAY when tx_busy=0.
  - PAY: tx_start=1, tx_data = payload. Next state P_ACK.
  - P_ACK / P_DONE: same rules as H_ACK / H_DONE; the exit is IDLE.
- tx_start is asserted only in HDR and PAY, and only ever for exactly one cycle.
- A frame, once granted, always completes. en low does not abort it.
- Reset, including mid-frame, takes effect asynchronously:
  - FSM -> IDLE; FIFOs empty.
  - tx_start=0, tx_data=0, src_drop=0, tx_err=0, drop_cnt=0.
  - last_grant=NSRC-1.

## Timing
- All outputs are registered.
- Latency: src_valid sampled at edge N into an idle system with tx_busy low -> grant at edge N+1 -> tx_start high during the cycle after edge N+1.
- FIFO occupancy is visible to the arbiter one cycle after the write.
- The header-to-payload gap is set by the UART: PAY starts the cycle after tx_busy is seen low in H_DONE.
- Back-to-back frames: IDLE is re-entered one cycle after tx_busy falls in P_DONE, and the next grant happens in that IDLE cycle.
- Minimum frame overhead beyond UART time is 2 cycles per byte: one start cycle plus one done-detect cycle.
- The timeout counter resets on entry to H_ACK or P_ACK and counts 1..ACK_TO.

## Structure
- Package dbg_uart_pkg holds:
  - the FSM state enum;
  - HDR_TAG = 4'hA;
  - the id width constant.
- Sub-module dbg_fifo: synchronous FIFO of DEPTH x 8 with push, pop, full, empty and a simultaneous push/pop rule. It is instantiated NSRC times.
- The arbiter and FSM live in the top. There are no other sub-modules.

## Test plan
- Single byte: src_valid[1] with 8'h5C; UART model raises busy 1 cycle after start and holds it 10 cycles. Required: tx_start two cycles after valid with tx_data=8'hA1, then tx_start with tx_data=8'h5C, then back to IDLE.
- Fairness: all three FIFOs pre-filled with 2 bytes each. Frames must go out in source order 0,1,2,0,1,2.
- Overflow: 6 writes to source 2 while the UART is held busy. Required: 4 bytes queued, src_drop[2] pulses twice, drop_cnt=2; 300 overflowing writes -> drop_cnt saturates at 255.
- Full FIFO with push and pop in the same cycle: no drop pulse, and the byte order out is preserved.
- UART never asserts busy. Required: tx_err pulses 16 cycles after each start, the frame still completes, and the FSM returns to IDLE.
- reset asserted during P_DONE: outputs clear immediately, the FIFOs are empty, and the next write is granted to source 0 first.
